countdown_mmss_bcd: RTL and testbench
=====================================

Name: countdown_mmss_bcd

Overview:
- Loadable packed-BCD minutes:seconds down-counter for the snooze/countdown timer path.
- Counts one BCD second per `tick` from a preset value down to 00:00, then flags expiry.
- Mirror of the up-counting mod-60 time counters: same BCD encoding (8'h00..8'h59 per field).
- Emits a borrow pulse on each seconds wrap 00→59, the counterpart of the up-counter's tc.

Parameters:
- MAX_BCD, 8'h59: largest legal value for either field; loads above this are rejected.
- HOLD_EXPIRED, 1: 1 = `expired` level held until load/reset; 0 = `expired` tracks the `done` pulse only.

Ports:
- clkin  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle, one-second enable.
- load  input  1  load request for preset value.
- load_min  input  8  preset minutes, packed BCD.
- load_sec  input  8  preset seconds, packed BCD.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- min  output  8  current minutes, packed BCD.
- sec  output  8  current seconds, packed BCD.
- running  output  1  high in RUN state.
- borrow  output  1  one-cycle pulse when sec wraps 00→59.
- done  output  1  one-cycle pulse when count reaches 00:00.
- expired  output  1  timer finished (see HOLD_EXPIRED).
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: clock is clkin. Reset is synchronous and active-high, named reset.
- Reset values: min=8'h00, sec=8'h00, running=0, borrow=0, done=0, expired=0, load_err=0, state=IDLE.
- Reset mid-count: abandons the count with no done or borrow pulse.
- Outputs: all registered. Effects appear the cycle after the qualifying input edge.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Priority per cycle: reset > load > stop > start > tick.
- Load, any state:
  - Accepted only if every nibble ≤ 9 and each tens nibble ≤ 5 (value ≤ MAX_BCD).
  - Accepted: min/sec take the preset, state→IDLE, expired cleared.
  - Rejected: load_err=1 for one cycle; value and state unchanged.
- IDLE:
  - start with value ≠ 00:00 → RUN.
  - start with value = 00:00 is ignored.
  - tick is ignored.
- RUN, tick decrement:
  - If sec ones ≠ 0: decrement ones.
  - Else if sec tens ≠ 0: ones=9, tens−1.
  - Else: sec=8'h59, borrow=1, min decremented with the same BCD rule.
- RUN, expiry:
  - A tick that makes the result 00:00 → state EXPIRED, done=1 for one cycle, expired=1.
  - done is coincident with min/sec showing 00:00.
  - No borrow on the final step.
- RUN, stop:
  - stop → PAUSE, no decrement that cycle, even with a simultaneous tick.
  - start+stop together: stop wins.
- PAUSE: start → RUN. tick is ignored. Value is held.
- EXPIRED:
  - Count held at 00:00. tick and start are ignored.
  - Leaves only via load (→IDLE) or reset.
  - HOLD_EXPIRED=0: expired deasserts the cycle after done.
- start coinciding with tick in IDLE/PAUSE: transition only; first decrement on the next tick.
- running=1 exactly while state=RUN.
- Arithmetic: minutes never wrap below 00, since 00:00 always terminates. Max preset 59:59 = 3599 ticks to expiry.

Decomposition:
- Shared package countdown_pkg:
  - State encoding constants: IDLE, RUN, PAUSE, EXPIRED.
  - BCD constants: BCD_ZERO=8'h00, BCD_MAX=8'h59, NIB_MAX=4'd9, TENS_MAX=4'd5.
  - BCD-valid check function.
- Sub-module bcd_dec60:
  - Combinational packed-BCD decrement of one 8-bit field, with wrap 00→59.
  - Outputs: next value and a borrow flag.
  - Instantiated twice: seconds, and minutes (minutes borrow unused).
- The top module holds the FSM and registers.

Test Plan:
- Load 01:00, start, 1 tick → sec=8'h59, min=8'h00, borrow=1 for one cycle; 59 more ticks → 00:00, done=1 one cycle, expired=1, running=0.
- Load 00:10, start, 3 ticks, stop + tick same cycle, 2 ticks → value stays 00:07; start, 7 ticks → done pulse.
- Load 8'h5A seconds or 8'h60 minutes → load_err=1 one cycle, prior value unchanged, state unchanged.
- Load 00:00 then start → remains IDLE, running=0, no done pulse.
- Load 59:59, start, 3599 ticks → exactly one done; borrow pulses counted = 59.
- Assert reset during RUN at 12:34 → next cycle all outputs zero, state IDLE; load during EXPIRED → expired cleared, IDLE with new value.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared state encoding, BCD constants and the load-validity check for the
// minutes:seconds countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_MAX  = 8'h59;
    localparam logic [3:0] NIB_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    // A field is loadable only if both nibbles are decimal digits, the tens
    // digit fits a mod-60 field, and the packed value does not exceed max_v.
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max_v);
        return (v[3:0] <= NIB_MAX) && (v[7:4] <= TENS_MAX) && (v <= max_v);
    endfunction

endpackage

// File: rtl/bcd_dec60.sv
// Combinational packed-BCD decrement of one mod-60 field; 00 wraps to 59
// and raises borrow_o.
module bcd_dec60
    import countdown_pkg::*;
(
    input  logic [7:0] val_i,
    output logic [7:0] dec_o,
    output logic       borrow_o
);

    always_comb begin
        dec_o    = val_i;
        borrow_o = 1'b0;
        if (val_i[3:0] != 4'd0) begin
            dec_o[3:0] = val_i[3:0] - 4'd1;
        end else if (val_i[7:4] != 4'd0) begin
            dec_o[3:0] = NIB_MAX;
            dec_o[7:4] = val_i[7:4] - 4'd1;
        end else begin
            dec_o    = BCD_MAX;
            borrow_o = 1'b1;
        end
    end

endmodule

// File: rtl/countdown_mmss_bcd.sv
// Loadable packed-BCD mm:ss down-counter: one second per tick, done/expired
// at 00:00, borrow pulse on every seconds wrap.
module countdown_mmss_bcd
    import countdown_pkg::*;
#(
    parameter logic [7:0] MAX_BCD      = 8'h59,
    parameter int         HOLD_EXPIRED = 1
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       borrow,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    state_t     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       borrow_q, borrow_d;
    logic       done_q, done_d;
    logic       expired_q, expired_d;
    logic       load_err_q, load_err_d;

    // Index 0 is seconds, index 1 is minutes.
    logic [1:0][7:0] field_cur;
    logic [1:0][7:0] field_dec;
    logic [1:0]      field_borrow;
    logic            unused_min_borrow;

    assign field_cur = {min_q, sec_q};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            bcd_dec60 u_dec (
                .val_i    (field_cur[gi]),
                .dec_o    (field_dec[gi]),
                .borrow_o (field_borrow[gi])
            );
        end
    endgenerate

    // Minutes can never wrap: a 00:00 result always ends the count first.
    assign unused_min_borrow = field_borrow[1];

    logic [7:0] sec_step;
    logic [7:0] min_step;
    logic       step_zero;
    logic       cur_zero;
    logic       load_ok;

    assign sec_step  = field_dec[0];
    assign min_step  = field_borrow[0] ? field_dec[1] : min_q;
    assign step_zero = (sec_step == BCD_ZERO) && (min_step == BCD_ZERO);
    assign cur_zero  = (sec_q == BCD_ZERO) && (min_q == BCD_ZERO);
    assign load_ok   = bcd_valid(load_min, MAX_BCD) && bcd_valid(load_sec, MAX_BCD);

    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        borrow_d   = 1'b0;
        done_d     = 1'b0;
        expired_d  = (HOLD_EXPIRED != 0) ? expired_q : 1'b0;
        load_err_d = 1'b0;

        if (load) begin
            if (load_ok) begin
                min_d     = load_min;
                sec_d     = load_sec;
                state_d   = IDLE;
                expired_d = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else if (start && (state_q == IDLE || state_q == PAUSE)) begin
            // A tick in the same cycle is swallowed; counting begins next tick.
            if (state_q == PAUSE || !cur_zero) begin
                state_d = RUN;
            end
        end else if (tick && state_q == RUN) begin
            sec_d = sec_step;
            min_d = min_step;
            if (step_zero) begin
                state_d   = EXPIRED;
                done_d    = 1'b1;
                expired_d = 1'b1;
            end else begin
                borrow_d = field_borrow[0];
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= IDLE;
            min_q      <= BCD_ZERO;
            sec_q      <= BCD_ZERO;
            borrow_q   <= 1'b0;
            done_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            borrow_q   <= borrow_d;
            done_q     <= done_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign min      = min_q;
    assign sec      = sec_q;
    assign running  = (state_q == RUN);
    assign borrow   = borrow_q;
    assign done     = done_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_mmss_bcd.sv
// Directed, table-driven bench for countdown_mmss_bcd with hand-written
// sequences for the long counts and reset/load corner cases.
module tb_countdown_mmss_bcd;

    logic       clkin = 1'b0;
    logic       reset;
    logic       tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       stop;
    logic [7:0] min;
    logic [7:0] sec;
    logic       running;
    logic       borrow;
    logic       done;
    logic       expired;
    logic       load_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clkin = ~clkin;

    countdown_mmss_bcd #(
        .MAX_BCD      (8'h59),
        .HOLD_EXPIRED (1)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .stop     (stop),
        .min      (min),
        .sec      (sec),
        .running  (running),
        .borrow   (borrow),
        .done     (done),
        .expired  (expired),
        .load_err (load_err)
    );

    typedef struct {
        logic       ld;
        logic [7:0] lmin;
        logic [7:0] lsec;
        logic       st;
        logic       sp;
        logic       tk;
        logic [7:0] emin;
        logic [7:0] esec;
        logic       erun;
        logic       ebor;
        logic       edone;
        logic       eexp;
        logic       eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [20:0] outs();
        return {min, sec, running, borrow, done, expired, load_err};
    endfunction

    function automatic logic [20:0] pack(input logic [7:0] m, input logic [7:0] s,
                                         input logic r, input logic b, input logic d,
                                         input logic e, input logic x);
        return {m, s, r, b, d, e, x};
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h:%h run=%b bor=%b done=%b exp=%b err=%b, want %h:%h run=%b bor=%b done=%b exp=%b err=%b",
                     name, got[20:13], got[12:5], got[4], got[3], got[2], got[1], got[0],
                     want[20:13], want[12:5], want[4], want[3], want[2], want[1], want[0]);
        end else begin
            $display("ok   %s: %h:%h run=%b bor=%b done=%b exp=%b err=%b",
                     name, got[20:13], got[12:5], got[4], got[3], got[2], got[1], got[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                         input logic st, input logic sp, input logic tk);
        load     = ld;
        load_min = lm;
        load_sec = ls;
        start    = st;
        stop     = sp;
        tick     = tk;
        @(posedge clkin);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic add(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                       input logic st, input logic sp, input logic tk,
                       input logic [7:0] em, input logic [7:0] es, input logic er,
                       input logic eb, input logic ed, input logic ee, input logic ex);
        vec_t v;
        v.ld = ld; v.lmin = lm; v.lsec = ls; v.st = st; v.sp = sp; v.tk = tk;
        v.emin = em; v.esec = es; v.erun = er; v.ebor = eb; v.edone = ed;
        v.eexp = ee; v.eerr = ex;
        vecs.push_back(v);
    endtask

    initial begin
        int done_cnt;
        int borrow_cnt;
        int done_at;

        reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
        load_min = 8'h00; load_sec = 8'h00;
        @(posedge clkin); #1;
        @(posedge clkin); #1;
        check("reset_state", outs(), '0);
        reset = 1'b0;

        // 01:00 -> borrow on first tick, then 59 ticks to expiry.
        drive(1, 8'h01, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 8'h00, 1, 0, 0);
        check("m1_start", outs(), pack(8'h01, 8'h00, 1, 0, 0, 0, 0));
        drive(0, 8'h00, 8'h00, 0, 0, 1);
        check("m1_wrap_borrow", outs(), pack(8'h00, 8'h59, 1, 1, 0, 0, 0));
        drive(0, 8'h00, 8'h00, 0, 0, 0);
        check("m1_borrow_1cyc", outs(), pack(8'h00, 8'h59, 1, 0, 0, 0, 0));
        done_cnt = 0;
        for (int i = 0; i < 58; i++) begin
            drive(0, 8'h00, 8'h00, 0, 0, 1);
            if (done) done_cnt++;
        end
        check_int("m1_no_early_done", done_cnt, 0);
        check("m1_at_0001", outs(), pack(8'h00, 8'h01, 1, 0, 0, 0, 0));
        drive(0, 8'h00, 8'h00, 0, 0, 1);
        check("m1_expire", outs(), pack(8'h00, 8'h00, 0, 0, 1, 1, 0));
        drive(0, 8'h00, 8'h00, 0, 0, 0);
        check("m1_done_1cyc", outs(), pack(8'h00, 8'h00, 0, 0, 0, 1, 0));

        //   ld  lmin   lsec   st sp tk   emin   esec   run bor done exp err
        add(1, 8'h00, 8'h10, 0, 0, 0,  8'h00, 8'h10, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 1, 0, 1,  8'h00, 8'h10, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h09, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h08, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h07, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 1, 1,  8'h00, 8'h07, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h07, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h07, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 1, 1, 0,  8'h00, 8'h07, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 1, 0, 0,  8'h00, 8'h07, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h06, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h05, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h04, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h03, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h02, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h01, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h00, 0, 0, 1, 1, 0);
        add(0, 8'h00, 8'h00, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0, 1, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h00, 0, 0, 0, 1, 0);
        add(0, 8'h00, 8'h00, 1, 0, 0,  8'h00, 8'h00, 0, 0, 0, 1, 0);
        add(1, 8'h60, 8'h00, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0, 1, 1);
        add(1, 8'h12, 8'h34, 0, 0, 0,  8'h12, 8'h34, 0, 0, 0, 0, 0);
        add(1, 8'h12, 8'h5A, 0, 0, 0,  8'h12, 8'h34, 0, 0, 0, 0, 1);
        add(0, 8'h00, 8'h00, 0, 0, 0,  8'h12, 8'h34, 0, 0, 0, 0, 0);
        add(1, 8'h0A, 8'h00, 0, 0, 0,  8'h12, 8'h34, 0, 0, 0, 0, 1);
        add(0, 8'h00, 8'h00, 1, 0, 0,  8'h12, 8'h34, 1, 0, 0, 0, 0);
        add(1, 8'h60, 8'h00, 0, 0, 1,  8'h12, 8'h34, 1, 0, 0, 0, 1);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h12, 8'h33, 1, 0, 0, 0, 0);
        add(1, 8'h00, 8'h00, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 1, 0, 1,  8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0, 0, 0);
        add(1, 8'h10, 8'h00, 0, 0, 0,  8'h10, 8'h00, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h10, 8'h00, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 1, 0, 0,  8'h10, 8'h00, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h09, 8'h59, 1, 1, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h09, 8'h58, 1, 0, 0, 0, 0);
        add(1, 8'h00, 8'h01, 0, 0, 0,  8'h00, 8'h01, 0, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 1, 0, 0,  8'h00, 8'h01, 1, 0, 0, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0, 1,  8'h00, 8'h00, 0, 0, 1, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lmin, vecs[i].lsec, vecs[i].st, vecs[i].sp, vecs[i].tk);
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].emin, vecs[i].esec, vecs[i].erun, vecs[i].ebor,
                       vecs[i].edone, vecs[i].eexp, vecs[i].eerr));
        end

        // Full-range count from 59:59: 3599 ticks, one done, 59 borrows.
        drive(1, 8'h59, 8'h59, 0, 0, 0);
        check("full_load", outs(), pack(8'h59, 8'h59, 0, 0, 0, 0, 0));
        drive(0, 8'h00, 8'h00, 1, 0, 0);
        done_cnt = 0; borrow_cnt = 0; done_at = -1;
        for (int i = 0; i < 3599; i++) begin
            drive(0, 8'h00, 8'h00, 0, 0, 1);
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (borrow) borrow_cnt++;
        end
        check_int("full_done_count", done_cnt, 1);
        check_int("full_done_tick", done_at, 3598);
        check_int("full_borrow_count", borrow_cnt, 59);
        check("full_end", outs(), pack(8'h00, 8'h00, 0, 0, 1, 1, 0));
        drive(0, 8'h00, 8'h00, 1, 0, 1);
        check("full_expired_hold", outs(), pack(8'h00, 8'h00, 0, 0, 0, 1, 0));
        drive(1, 8'h03, 8'h21, 0, 0, 0);
        check("load_in_expired", outs(), pack(8'h03, 8'h21, 0, 0, 0, 0, 0));

        // Reset while running at 12:34 abandons the count silently.
        drive(1, 8'h12, 8'h34, 0, 0, 0);
        drive(0, 8'h00, 8'h00, 1, 0, 0);
        check("rst_running", outs(), pack(8'h12, 8'h34, 1, 0, 0, 0, 0));
        reset = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 0, 1);
        reset = 1'b0;
        check("rst_mid_run", outs(), '0);
        drive(0, 8'h00, 8'h00, 1, 0, 1);
        check("rst_then_idle", outs(), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
